md_sched: RTL and testbench

MD_SCHED -- requirements
Module: md_sched

---
 rtl/md_sched_pkg.sv | 43 ++++
 rtl/md_sched_lat_cnt.sv | 34 +++
 rtl/md_sched.sv | 107 ++++++++++
 tb/tb_md_sched.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared mul/div encodings: op codes, scheduler state and small decode helpers.
// The mul/div datapath decodes the same op encoding.
package md_sched_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Raw op field to enum; anything outside the encoding behaves as OP_NONE.
    function automatic md_op_e decode_op(input logic [3:0] raw);
        case (raw)
            4'd1:    return OP_MULT;
            4'd2:    return OP_MULTU;
            4'd3:    return OP_DIV;
            4'd4:    return OP_DIVU;
            4'd5:    return OP_MTHI;
            4'd6:    return OP_MTLO;
            default: return OP_NONE;
        endcase
    endfunction

    // Ops that occupy the multi-cycle mul/div unit.
    function automatic logic is_launch_op(input md_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_sched_lat_cnt.sv
// Latency down-counter: loads LAT-1 for the launched op class, then counts down to zero.
module md_lat_cnt
    import md_sched_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       sel_div,
    input  logic       dec,
    output logic [3:0] value,
    output logic       zero
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_LAT - 1);

    // Remaining-cycle register: load has priority over decrement, never wraps below zero.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= sel_div ? DIV_LOAD : MUL_LOAD;
        end else if (dec && !zero) begin
            value <= value - 4'd1;
        end
    end

    assign zero = (value == 4'd0);

endmodule

// File: rtl/md_sched.sv
// Mul/div scheduler: launches HI/LO ops, tracks the busy window, stalls D,
// gates MTHI/MTLO and flags protocol violations.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        e_valid,
    input  logic [3:0]  e_op,
    input  logic        d_md_use,
    output logic        start,
    output logic        busy,
    output logic        stall_d,
    output logic        done,
    output logic        hi_we,
    output logic        lo_we,
    output logic [3:0]  cnt,
    output logic [15:0] ops_done,
    output logic        proto_err
);

    md_state_e  state, state_next;
    md_op_e     op;
    logic       issue, launch, mthi_req, mtlo_req;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic [15:0] ops_done_q;
    logic       proto_err_q;

    // A flushed (req) E-stage instruction never issues anything.
    assign op       = decode_op(e_op);
    assign issue    = e_valid & ~req;
    assign launch   = issue & is_launch_op(op);
    assign mthi_req = issue & (op == OP_MTHI);
    assign mtlo_req = issue & (op == OP_MTLO);

    md_lat_cnt #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_lat_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .sel_div (is_div_op(op)),
        .dec     (cnt_dec),
        .value   (cnt),
        .zero    (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and strobes; reset suppresses start and the done pulse.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        done       = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (launch && !reset) begin
                    start      = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_dec = ~cnt_zero;
                if (cnt == 4'd1) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = ~reset;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy    = (state != ST_IDLE);
    assign stall_d = d_md_use & (busy | start);
    assign hi_we   = mthi_req & (state == ST_IDLE);
    assign lo_we   = mtlo_req & (state == ST_IDLE);

    // Committed-op counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset)                   ops_done_q <= '0;
        else if (state == ST_DONE)   ops_done_q <= ops_done_q + 16'd1;
    end

    // Sticky violation: any HI/LO-touching E op arriving while the unit is occupied.
    always_ff @(posedge clk) begin
        if (reset)                                        proto_err_q <= 1'b0;
        else if (busy && (launch || mthi_req || mtlo_req)) proto_err_q <= 1'b1;
    end

    assign ops_done  = ops_done_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_md_sched;
    import md_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset, req, e_valid, d_md_use;
    logic [3:0]  e_op;
    logic        start, busy, stall_d, done, hi_we, lo_we, proto_err;
    logic [3:0]  cnt;
    logic [15:0] ops_done;

    typedef struct packed {
        logic        chk_all;
        logic        start, busy, stall_d, done, hi_we, lo_we, proto_err;
        logic [3:0]  cnt;
        logic [15:0] ops;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    md_sched #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .req(req), .e_valid(e_valid), .e_op(e_op),
        .d_md_use(d_md_use), .start(start), .busy(busy), .stall_d(stall_d),
        .done(done), .hi_we(hi_we), .lo_we(lo_we), .cnt(cnt),
        .ops_done(ops_done), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    function automatic exp_t ex(input logic st, bz, sd, dn, hw, lw, pe, input int c, input int o);
        exp_t e;
        e.chk_all = 1'b1;
        e.start = st; e.busy = bz; e.stall_d = sd; e.done = dn;
        e.hi_we = hw; e.lo_we = lw; e.proto_err = pe;
        e.cnt = 4'(c); e.ops = 16'(o);
        return e;
    endfunction

    // Monitor: compares DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("start", 16'(start), 16'(e.start));
            if (e.chk_all) begin
                check("busy",      16'(busy),      16'(e.busy));
                check("stall_d",   16'(stall_d),   16'(e.stall_d));
                check("done",      16'(done),      16'(e.done));
                check("hi_we",     16'(hi_we),     16'(e.hi_we));
                check("lo_we",     16'(lo_we),     16'(e.lo_we));
                check("proto_err", 16'(proto_err), 16'(e.proto_err));
                check("cnt",       16'(cnt),       16'(e.cnt));
                check("ops_done",  ops_done,       e.ops);
            end
        end
    end

    task automatic step(input logic rst, v, rq, input logic [3:0] op, input logic use_md, input exp_t e);
        @(posedge clk);
        #1;
        reset = rst; e_valid = v; req = rq; e_op = op; d_md_use = use_md;
        exp_q.push_back(e);
    endtask

    // Reset cycle with a MULT presented: start must stay low while reset is high.
    task automatic do_reset();
        exp_t e;
        e = ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e.chk_all = 1'b0;
        step(1, 1, 0, OP_MULT, 0, e);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; req = 1'b0; e_valid = 1'b0; e_op = 4'd0; d_md_use = 1'b0;
        repeat (2) @(posedge clk);

        // MULT with d_md_use held: start@0, busy 1..5, cnt 4..0, done@5.
        do_reset();
        step(0, 1, 0, OP_MULT, 1, ex(1, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 5; k++)
            step(0, 0, 0, OP_NONE, 1, ex(0, 1, 1, k == 5, 0, 0, 0, 5 - k, 0));
        step(0, 0, 0, OP_NONE, 1, ex(0, 0, 0, 0, 0, 0, 0, 0, 1));

        // DIVU flushed by req, then re-issued: busy 2..11, done@11.
        do_reset();
        step(0, 1, 1, OP_DIVU, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 1, 0, OP_DIVU, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 2; k <= 11; k++)
            step(0, 0, 0, OP_NONE, 0, ex(0, 1, 0, k == 11, 0, 0, 0, 11 - k, 0));
        step(0, 0, 0, OP_NONE, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 1));

        // DIV with MTHI at 4: ignored, proto_err from 5, done@10; MTHI in IDLE writes.
        do_reset();
        step(0, 1, 0, OP_DIV, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 10; k++)
            step(0, k == 4, 0, (k == 4) ? OP_MTHI : OP_NONE, 0,
                 ex(0, 1, 0, k == 10, 0, 0, k >= 5, 10 - k, 0));
        step(0, 0, 0, OP_NONE, 0, ex(0, 0, 0, 0, 0, 0, 1, 0, 1));
        step(0, 1, 0, OP_MTHI, 0, ex(0, 0, 0, 0, 1, 0, 1, 0, 1));

        // MULT aborted by reset at 3; MTLO at 5; out-of-range and flushed ops do nothing.
        do_reset();
        step(0, 1, 0, OP_MULT, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, OP_NONE, 0, ex(0, 1, 0, 0, 0, 0, 0, 4, 0));
        step(0, 0, 0, OP_NONE, 0, ex(0, 1, 0, 0, 0, 0, 0, 3, 0));
        step(1, 0, 0, OP_NONE, 0, ex(0, 1, 0, 0, 0, 0, 0, 2, 0));
        step(0, 0, 0, OP_NONE, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 1, 0, OP_MTLO, 0, ex(0, 0, 0, 0, 0, 1, 0, 0, 0));
        step(0, 1, 0, 4'hF,    1, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 1, 0, 4'h7,    0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 1, 1, OP_MTHI, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, OP_NONE, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset landing in DONE: no done pulse, no count.
        do_reset();
        step(0, 1, 0, OP_MULT, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 4; k++)
            step(0, 0, 0, OP_NONE, 0, ex(0, 1, 0, 0, 0, 0, 0, 5 - k, 0));
        step(1, 0, 0, OP_NONE, 0, ex(0, 1, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, OP_NONE, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // MULT, second MULT in DONE ignored (proto_err), third MULT one cycle later runs.
        do_reset();
        step(0, 1, 0, OP_MULT, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 5; k++)
            step(0, k == 5, 0, (k == 5) ? OP_MULT : OP_NONE, 0,
                 ex(0, 1, 0, k == 5, 0, 0, 0, 5 - k, 0));
        step(0, 1, 0, OP_MULT, 0, ex(1, 0, 0, 0, 0, 0, 1, 0, 1));
        for (int k = 7; k <= 11; k++)
            step(0, 0, 0, OP_NONE, 0, ex(0, 1, 0, k == 11, 0, 0, 1, 11 - k, 1));
        step(0, 0, 0, OP_NONE, 0, ex(0, 0, 0, 0, 0, 0, 1, 0, 2));

        // Counter at 0xFFFF (stands in for 65535 prior MULTU commits); one more wraps to 0.
        do_reset();
        force dut.ops_done_q = 16'hFFFF;
        e = ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e.chk_all = 1'b0;
        step(0, 0, 0, OP_NONE, 0, e);
        release dut.ops_done_q;
        step(0, 1, 0, OP_MULTU, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF));
        for (int k = 1; k <= 5; k++)
            step(0, 0, 0, OP_NONE, 0, ex(0, 1, 0, k == 5, 0, 0, 0, 5 - k, 16'hFFFF));
        step(0, 0, 0, OP_NONE, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));

        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
